// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract sequenced through one external 4-bit CLA slice,
// one nibble per clock (LSB first), with valid/ready on both sides.
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_sum,
  input  logic             slice_cout
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_sub;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_cnt == CW'(NIB - 1));
  assign w_a_sh   = r_a >> {r_cnt, 2'b00};
  assign w_b_sh   = r_b >> {r_cnt, 2'b00};
  assign w_a_nib  = w_a_sh[3:0];
  assign w_b_nib  = w_b_sh[3:0];

  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        busy      = 1'b1;
        slice_a   = w_a_nib;
        slice_b   = w_b_nib ^ {4{r_sub}};
        slice_cin = r_carry;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= op_a;
      r_b      <= op_b;
      r_sub    <= op_sub;
      r_carry  <= op_sub | op_cin;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (r_state == S_RUN) begin
      for (int unsigned i = 0; i < NIB; i++) begin
        if (r_cnt == CW'(i)) r_result[4*i +: 4] <= slice_sum;
      end
      r_carry <= slice_cout;
      // Counter parks on the last nibble instead of wrapping.
      if (!w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cout <= slice_cout;
        r_ovf  <= (r_a[WIDTH-1] == (r_b[WIDTH-1] ^ r_sub)) &&
                  (slice_sum[3] != r_a[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: directed and random operations checked
// against a whole-word arithmetic model, with a behavioural 4-bit slice.
module tb_nibble_serial_add_ctrl;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic [3:0]   slice_a;
  logic [3:0]   slice_b;
  logic         slice_cin;
  logic [3:0]   slice_sum;
  logic         slice_cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .busy(busy),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_sum(slice_sum), .slice_cout(slice_cout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Carry entering nibble k: carry out of the low 4k bits of the full sum.
  function automatic logic cin_at(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c, input int k);
    logic [W:0] m;
    logic [W:0] t;
    if (k == 0) return c;
    m = ({{W{1'b0}}, 1'b1} << (4 * k)) - 1'b1;
    t = ({1'b0, a} & m) + ({1'b0, b} & m) + {{W{1'b0}}, c};
    return t[4*k];
  endfunction

  task automatic check_idle_cleared(input string tag);
    chk({tag, "_in_ready"},  in_ready,  1'b1);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_busy"},      busy,      1'b0);
    chk({tag, "_result"},    result,    '0);
    chk({tag, "_cout"},      cout,      1'b0);
    chk({tag, "_ovf"},       ovf,       1'b0);
    chk({tag, "_slice"},     {slice_a, slice_b, slice_cin}, '0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input int hold);
    logic [W-1:0] beff;
    logic [W:0]   s;
    logic         c0;
    logic         e_ovf;
    beff  = sub ? ~b : b;
    c0    = sub ? 1'b1 : cin;
    s     = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, c0};
    e_ovf = (a[W-1] == beff[W-1]) && (s[W-1] != a[W-1]);

    in_valid = 1'b1; op_a = a; op_b = b; op_cin = cin; op_sub = sub;
    chk("accept_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom);
    op_cin = 1'($urandom); op_sub = 1'($urandom);
    for (int k = 0; k < int'(NIB); k++) begin
      chk("run_slice_a",   slice_a,   4'((a >> (4 * k)) & 4'hF));
      chk("run_slice_b",   slice_b,   4'((beff >> (4 * k)) & 4'hF));
      chk("run_slice_cin", slice_cin, cin_at(a, beff, c0, k));
      chk("run_in_ready",  in_ready,  1'b0);
      chk("run_out_valid", out_valid, 1'b0);
      chk("run_busy",      busy,      1'b1);
      in_valid = 1'($urandom);
      tick();
    end
    for (int h = 0; h <= hold; h++) begin
      chk("done_out_valid", out_valid, 1'b1);
      chk("done_in_ready",  in_ready,  1'b0);
      chk("done_busy",      busy,      1'b1);
      chk("done_result",    result,    s[W-1:0]);
      chk("done_cout",      cout,      s[W]);
      chk("done_ovf",       ovf,       e_ovf);
      chk("done_slice",     {slice_a, slice_b, slice_cin}, '0);
      if (h < hold) begin
        out_ready = 1'b0;
        in_valid  = 1'($urandom);
        tick();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_in_ready",  in_ready,  1'b1);
    chk("post_out_valid", out_valid, 1'b0);
    chk("post_busy",      busy,      1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0; op_sub = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_idle_cleared("reset");

    // Reset wins over a same-cycle request.
    in_valid = 1'b1; op_a = 16'h1111; op_b = 16'h2222; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check_idle_cleared("rst_prio");

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 3);
    run_op(16'h00FF, 16'h0F01, 1'b1, 1'b0, 2);

    // Abort in RUN after two nibbles.
    in_valid = 1'b1; op_a = 16'hABCD; op_b = 16'h1234; op_cin = 1'b0; op_sub = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_cleared("abort_run");
    for (int i = 0; i < int'(NIB) + 2; i++) begin
      chk("abort_run_no_valid", out_valid, 1'b0);
      tick();
    end
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

    // Abort in DONE.
    in_valid = 1'b1; op_a = 16'hF000; op_b = 16'hF000; op_cin = 1'b1; op_sub = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < int'(NIB); i++) tick();
    chk("abort_done_valid", out_valid, 1'b1);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    check_idle_cleared("abort_done");

    for (int n = 0; n < 40; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
